// File: rtl/multi_operand_summer_if.sv
// Handshake bundle for multi_operand_summer: operand-set input channel and
// result output channel. The producer/consumer side uses master, the summer uses slave.
interface multi_operand_summer_if #(
    parameter int NUM_IN    = 16,
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 32
);
    logic                         in_valid;
    logic                         in_ready;
    logic [NUM_IN*IN_WIDTH-1:0]   in_data;
    logic [NUM_IN-1:0]            in_mask;
    logic                         out_valid;
    logic                         out_ready;
    logic [OUT_WIDTH-1:0]         out_sum;
    logic                         out_ovf;

    modport master (
        output in_valid, in_data, in_mask, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_mask, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/multi_operand_summer.sv
// Time-multiplexed multi-operand adder: captures NUM_IN operands in one transfer
// and reduces them LANES per cycle into a non-overflowing accumulator.
module multi_operand_summer #(
    parameter int NUM_IN    = 16,
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 32,
    parameter int LANES     = 4,
    parameter int SIGNED    = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    multi_operand_summer_if.slave io_bus,
    output logic                 o_busy
);
    localparam int G      = (NUM_IN + LANES - 1) / LANES;
    localparam int NEED_W = IN_WIDTH + $clog2(NUM_IN) + 1;
    localparam int ACC_W  = (OUT_WIDTH > NEED_W) ? OUT_WIDTH : NEED_W;
    localparam int CNT_W  = (G > 1) ? $clog2(G) : 1;
    localparam int TOT_W  = G * LANES * IN_WIDTH;
    localparam int IDX_W  = $clog2(TOT_W) + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t               r_state;
    logic [TOT_W-1:0]     r_ops;
    logic [ACC_W-1:0]     r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [OUT_WIDTH-1:0] r_sum;
    logic                 r_ovf;
    logic                 r_busy;

    logic [NUM_IN*IN_WIDTH-1:0] w_masked;
    logic [IDX_W-1:0]           w_base;
    logic [ACC_W-1:0]           w_ext [LANES];
    logic [ACC_W-1:0]           w_group;
    logic [ACC_W-1:0]           w_acc_next;
    logic                       w_ovf;

    // Masking is applied at capture so the padded tail and masked operands are both plain zeros.
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_mask
        assign w_masked[gi*IN_WIDTH +: IN_WIDTH] =
            io_bus.in_mask[gi] ? io_bus.in_data[gi*IN_WIDTH +: IN_WIDTH] : '0;
    end

    assign w_base = IDX_W'(r_cnt) * IDX_W'(LANES * IN_WIDTH);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [IN_WIDTH-1:0] w_op;
        assign w_op = r_ops[w_base + IDX_W'(gi * IN_WIDTH) +: IN_WIDTH];
        if (SIGNED != 0) begin : g_sext
            assign w_ext[gi] = {{(ACC_W-IN_WIDTH){w_op[IN_WIDTH-1]}}, w_op};
        end else begin : g_zext
            assign w_ext[gi] = {{(ACC_W-IN_WIDTH){1'b0}}, w_op};
        end
    end

    always_comb begin
        w_group = '0;
        for (int i = 0; i < LANES; i++) begin
            w_group = w_group + w_ext[i];
        end
    end

    assign w_acc_next = r_acc + w_group;

    if (ACC_W == OUT_WIDTH) begin : g_no_ovf
        assign w_ovf = 1'b0;
    end else if (SIGNED != 0) begin : g_ovf_s
        assign w_ovf = ~((&w_acc_next[ACC_W-1:OUT_WIDTH-1]) | ~(|w_acc_next[ACC_W-1:OUT_WIDTH-1]));
    end else begin : g_ovf_u
        assign w_ovf = |w_acc_next[ACC_W-1:OUT_WIDTH];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_ops       <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_bus.in_valid) begin
                        r_ops      <= TOT_W'(w_masked);
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(G - 1)) begin
                        r_sum       <= w_acc_next[OUT_WIDTH-1:0];
                        r_ovf       <= w_ovf;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (io_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_sum   = r_sum;
    assign io_bus.out_ovf   = r_ovf;
    assign o_busy           = r_busy;
endmodule
